axis_to_sbus: RTL and testbench
===============================

Name: axis_to_sbus

Overview:
- Converts an AXI4-Stream slave interface into the internal push-only streaming bus (SBUS) used downstream of the packet source (net2axis_master).
- Every accepted AXIS beat is registered and re-emitted one cycle later with an 8-bit control word.
  - The control word carries start-of-packet, end-of-packet and the valid-byte count of the beat.
- SBUS has no backpressure, so the block never stalls its source once out of reset.

Parameters:
- TDATA_WIDTH, 256, data width in bits. Legal values: 64, 128, 256.
- KEEP_WIDTH, TDATA_WIDTH/8, derived local parameter; do not override.

Ports:
- ACLK  input  1  clock; all logic on the rising edge.
- ARESET  input  1  reset; synchronous, active-high.
- S_AXIS_TVALID  input  1  source beat valid.
- S_AXIS_TDATA  input  TDATA_WIDTH  source data; byte 0 = bits [7:0].
- S_AXIS_TKEEP  input  KEEP_WIDTH  byte enables; bit i qualifies byte i.
- S_AXIS_TLAST  input  1  last beat of packet.
- S_AXIS_TREADY  output  1  block can accept a beat.
- M_SBUS_VALID  output  1  SBUS beat valid.
- M_SBUS_TDATA  output  TDATA_WIDTH  SBUS data.
- M_SBUS_TKEEP  output  KEEP_WIDTH  SBUS byte enables.
- M_SBUS_CTL  output  8  control word: [0] SOP, [1] EOP, [7:2] valid-byte count.

Behaviour:
- Reset values:
  - S_AXIS_TREADY=0.
  - M_SBUS_VALID=0, M_SBUS_TDATA=0, M_SBUS_TKEEP=0, M_SBUS_CTL=0.
  - Internal in_pkt flag=0.
- TREADY:
  - Registered. Goes to 1 on the first clock edge with ARESET=0 and stays 1.
  - Drops to 0 in the same edge ARESET is sampled high.
- Accept: a beat is accepted on any edge where S_AXIS_TVALID && S_AXIS_TREADY.
- Latency:
  - An accepted beat appears on SBUS exactly 1 cycle later with M_SBUS_VALID=1 for exactly one cycle per beat.
  - Back-to-back accepts produce back-to-back SBUS beats.
  - Throughput: 1 beat/cycle.
- Idle cycles (no accept): M_SBUS_VALID=0, and TDATA, TKEEP and CTL are driven to 0.
- Data and keep: passed through unmodified.
- SOP:
  - CTL[0]=1 when the beat is accepted with in_pkt==0.
  - in_pkt is set on an accepted beat with TLAST=0 and cleared on an accepted beat with TLAST=1.
  - in_pkt is unchanged on cycles with no accept.
- EOP: CTL[1]=TLAST of the accepted beat.
- Single-beat packet: CTL[1:0]=2'b11.
- Byte count:
  - CTL[7:2] = popcount(S_AXIS_TKEEP), zero-extended to 6 bits.
  - Range 0..KEEP_WIDTH; 32 fits for 256-bit.
- TKEEP=0 beat: forwarded with count 0; SOP/EOP tracking still applies.
- TVALID deasserted mid-packet: SBUS goes idle; in_pkt is held, so the next beat is not SOP.
- Reset mid-packet:
  - Outputs clear on the next edge and in_pkt clears.
  - The first beat after reset is marked SOP regardless of where the prior packet was.
- No beat is accepted or emitted on any edge where ARESET=1.

Optional Feature:
- Macro: SBUS_KEEP_CHECK_EN.
- Defined:
  - Each accepted beat's TKEEP is checked for LSB-aligned contiguity, i.e. of the form 0…01…1 (all-zero is legal).
  - A non-contiguous TKEEP forces CTL[7:2]=6'h3F as an error marker.
  - SOP/EOP, data and keep are still forwarded unchanged.
- Undefined: no check; CTL[7:2] is always the popcount.

Test Plan:
- Reset: ARESET=1 for 12 cycles, then 0 → all outputs 0 during reset; TREADY=1 one edge after release.
- Single-beat packet: TVALID=1, TLAST=1, TKEEP=32'h0000_FFFF, TDATA=X → next cycle VALID=1, TDATA=X, CTL=8'h43 (count 16, SOP, EOP).
- 3-beat packet: TKEEP all-ones, then all-ones, then 32'h0000_000F with TLAST on beat 3 → CTL = 8'h81, 8'h80, 8'h12 on consecutive cycles.
- Gap mid-packet: beat 1 (no TLAST), TVALID=0 for 4 cycles, beat 2 with TLAST → VALID low for 4 cycles; beat 2 CTL[0]=0, CTL[1]=1.
- Reset mid-packet: beat 1 of a packet, assert ARESET 2 cycles, release, then send a beat → post-reset beat has CTL[0]=1.
- With SBUS_KEEP_CHECK_EN: TKEEP=32'h0000_00F0 → CTL[7:2]=6'h3F. Without the macro → CTL[7:2]=4.

Source files
------------

// File: rtl/axis_to_sbus.sv
// AXI4-Stream slave to push-only SBUS bridge: one registered beat per accept.
// Optional TKEEP contiguity check enabled by defining SBUS_KEEP_CHECK_EN.
module axis_to_sbus #(
    parameter  int TDATA_WIDTH = 256,
    localparam int KEEP_WIDTH  = TDATA_WIDTH / 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   S_AXIS_TVALID,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [KEEP_WIDTH-1:0]  S_AXIS_TKEEP,
    input  logic                   S_AXIS_TLAST,
    output logic                   S_AXIS_TREADY,
    output logic                   M_SBUS_VALID,
    output logic [TDATA_WIDTH-1:0] M_SBUS_TDATA,
    output logic [KEEP_WIDTH-1:0]  M_SBUS_TKEEP,
    output logic [7:0]             M_SBUS_CTL
);

    logic                   r_tready;
    logic                   r_valid;
    logic [TDATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0]  r_keep;
    logic [7:0]             r_ctl;
    logic                   r_in_pkt;

    logic                   w_accept;
    logic [5:0]             w_popcnt;
    logic [5:0]             w_cnt;

    assign w_accept = S_AXIS_TVALID && r_tready;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_popcnt = w_popcnt + {5'd0, S_AXIS_TKEEP[i]};
        end
    end

`ifdef SBUS_KEEP_CHECK_EN
    logic w_contig;

    // keep+1 clears the low run of ones; any surviving bit means a hole
    assign w_contig = ((S_AXIS_TKEEP & (S_AXIS_TKEEP + KEEP_WIDTH'(1))) == '0);
    assign w_cnt    = w_contig ? w_popcnt : 6'h3F;
`else
    assign w_cnt    = w_popcnt;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_tready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_keep   <= '0;
            r_ctl    <= '0;
            r_in_pkt <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            r_valid  <= w_accept;
            if (w_accept) begin
                r_data   <= S_AXIS_TDATA;
                r_keep   <= S_AXIS_TKEEP;
                r_ctl    <= {w_cnt, S_AXIS_TLAST, !r_in_pkt};
                r_in_pkt <= !S_AXIS_TLAST;
            end else begin
                r_data   <= '0;
                r_keep   <= '0;
                r_ctl    <= '0;
            end
        end
    end

    assign S_AXIS_TREADY = r_tready;
    assign M_SBUS_VALID  = r_valid;
    assign M_SBUS_TDATA  = r_data;
    assign M_SBUS_TKEEP  = r_keep;
    assign M_SBUS_CTL    = r_ctl;

endmodule

// File: tb/tb_axis_to_sbus.sv
// Bench for axis_to_sbus: directed plan steps plus randomized traffic
// checked against a packet-level reference model.
module tb_axis_to_sbus;

    localparam int TDW = 256;
    localparam int KW  = TDW / 8;

    logic           clk;
    logic           areset;
    logic           tvalid;
    logic [TDW-1:0] tdata;
    logic [KW-1:0]  tkeep;
    logic           tlast;
    logic           tready;
    logic           m_valid;
    logic [TDW-1:0] m_data;
    logic [KW-1:0]  m_keep;
    logic [7:0]     m_ctl;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit             m_ready = 1'b0;
    int             m_beats = 0;
    logic           e_valid;
    logic [TDW-1:0] e_data;
    logic [KW-1:0]  e_keep;
    logic [7:0]     e_ctl;

    axis_to_sbus #(.TDATA_WIDTH(TDW)) dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TKEEP  (tkeep),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .M_SBUS_VALID  (m_valid),
        .M_SBUS_TDATA  (m_data),
        .M_SBUS_TKEEP  (m_keep),
        .M_SBUS_CTL    (m_ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TDW-1:0] obs,
                       input logic [TDW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_contig(input logic [KW-1:0] k);
        bit seen_zero = 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (!k[i]) seen_zero = 1'b1;
            else if (seen_zero) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [TDW-1:0] rand_data();
        logic [TDW-1:0] d;
        for (int i = 0; i < TDW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic drv(input logic v, input logic l,
                       input logic [KW-1:0] k, input logic [TDW-1:0] d);
        tvalid = v;
        tlast  = l;
        tkeep  = k;
        tdata  = d;
    endtask

    // predict the result of the coming edge, advance it, compare
    task automatic tick();
        bit         acc;
        logic [5:0] cnt;
        acc = !areset && tvalid && m_ready;
        cnt = 6'($countones(tkeep));
`ifdef SBUS_KEEP_CHECK_EN
        if (!is_contig(tkeep)) cnt = 6'h3F;
`endif
        e_valid = acc;
        e_data  = acc ? tdata : '0;
        e_keep  = acc ? tkeep : '0;
        e_ctl   = acc ? {cnt, tlast, 1'(m_beats == 0)} : 8'h00;
        if (areset) m_beats = 0;
        else if (acc) m_beats = tlast ? 0 : m_beats + 1;
        m_ready = !areset;
        @(posedge clk);
        #1;
        chk("tready", TDW'(tready), TDW'(m_ready));
        chk("valid", TDW'(m_valid), TDW'(e_valid));
        chk("tdata", m_data, e_data);
        chk("tkeep", TDW'(m_keep), TDW'(e_keep));
        chk("ctl", TDW'(m_ctl), TDW'(e_ctl));
    endtask

    initial begin
        logic [KW-1:0]  k;
        logic [TDW-1:0] d;
        int             n;

        areset = 1'b1;
        drv(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) drv(1'b1, 1'b1, '1, rand_data());
            tick();
            chk("rst_ctl_zero", TDW'(m_ctl), '0);
        end
        drv(1'b0, 1'b0, '0, '0);
        areset = 1'b0;
        tick();
        chk("tready_after_release", TDW'(tready), TDW'(1'b1));

        // single-beat packet
        d = rand_data();
        drv(1'b1, 1'b1, 32'h0000_FFFF, d);
        tick();
        chk("single_ctl", TDW'(m_ctl), TDW'(8'h43));
        chk("single_data", m_data, d);

        // 3-beat packet
        drv(1'b1, 1'b0, 32'hFFFF_FFFF, rand_data());
        tick();
        chk("p3_b1_ctl", TDW'(m_ctl), TDW'(8'h81));
        drv(1'b1, 1'b0, 32'hFFFF_FFFF, rand_data());
        tick();
        chk("p3_b2_ctl", TDW'(m_ctl), TDW'(8'h80));
        drv(1'b1, 1'b1, 32'h0000_000F, rand_data());
        tick();
        chk("p3_b3_ctl", TDW'(m_ctl), TDW'(8'h12));

        // gap mid-packet
        drv(1'b1, 1'b0, 32'h0000_00FF, rand_data());
        tick();
        drv(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_valid_low", TDW'(m_valid), TDW'(1'b0));
        end
        drv(1'b1, 1'b1, 32'h0000_0003, rand_data());
        tick();
        chk("gap_b2_sop_eop", TDW'(m_ctl[1:0]), TDW'(2'b10));

        // zero-keep beat inside a packet
        drv(1'b1, 1'b0, 32'h0000_0001, rand_data());
        tick();
        drv(1'b1, 1'b1, 32'h0000_0000, rand_data());
        tick();
        chk("zero_keep_ctl", TDW'(m_ctl), TDW'(8'h02));

        // reset mid-packet
        drv(1'b1, 1'b0, 32'hFFFF_FFFF, rand_data());
        tick();
        drv(1'b0, 1'b0, '0, '0);
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
        drv(1'b1, 1'b0, 32'h0000_00FF, rand_data());
        tick();
        chk("post_reset_sop", TDW'(m_ctl[0]), TDW'(1'b1));
        drv(1'b1, 1'b1, 32'h0000_00FF, rand_data());
        tick();

        // non-contiguous keep
        drv(1'b1, 1'b1, 32'h0000_00F0, rand_data());
        tick();
`ifdef SBUS_KEEP_CHECK_EN
        chk("noncontig_ctl", TDW'(m_ctl), TDW'(8'hFF));
`else
        chk("noncontig_ctl", TDW'(m_ctl), TDW'(8'h13));
`endif

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            areset = ($urandom_range(0, 59) == 0);
            n = $urandom_range(0, KW);
            if ($urandom_range(0, 3) == 0) k = KW'($urandom());
            else if (n == KW) k = '1;
            else k = (KW'(1) << n) - KW'(1);
            drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                k, rand_data());
            tick();
        end
        areset = 1'b0;
        drv(1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
